// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match controller.
//   state_e            : match state encoding (IDLE/SERVE/PLAY/OVER)
//   WinScoreDefault    : default points needed to win
//   PauseTicksDefault  : default serve pause length in refresh ticks
//   ScoreW / TimerW    : shadow score and pause timer widths
package pong_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StServe = 2'd1,
    StPlay  = 2'd2,
    StOver  = 2'd3
  } state_e;

  localparam int unsigned WinScoreDefault   = 11;
  localparam int unsigned PauseTicksDefault = 120;
  localparam int unsigned ScoreW            = 7;
  localparam int unsigned TimerW            = 8;

endpackage

// File: rtl/pong_pause_timer.sv
// Load/decrement-on-tick down counter with an expiry flag.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (wins over tick in the same cycle)
//   load_val   : reload value
//   tick       : decrement enable; count saturates at 0
//   done       : count already 0, or this tick takes it from 1 to 0
module pong_pause_timer
  import pong_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [TimerW-1:0] load_val,
  input  logic              tick,
  output logic              done
);

  logic [TimerW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - TimerW'(1);
    end
  end

  assign done = (count_q == '0) || (tick && (count_q == TimerW'(1)));

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-level controller for pong: turns ball misses into score-counter
// pulses, sequences the serve pause, detects the winner and freezes play.
//   clk, reset          : clock, synchronous active-high reset
//   refr_tick           : one-cycle frame tick
//   btn_start           : debounced start/restart level
//   miss_A / miss_B     : ball passed A's / B's paddle (point to B / A)
//   d_inc_A/d_inc_B/d_clr : one-cycle score counter commands
//   ball_reset          : one-cycle ball re-centre pulse
//   graph_still         : ball/paddles frozen
//   game_over, winner   : match finished, 0 = A won, 1 = B won
//   state_dbg           : current state encoding
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = WinScoreDefault,
  parameter int unsigned PAUSE_TICKS = PauseTicksDefault
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic       btn_start,
  input  logic       miss_A,
  input  logic       miss_B,
  output logic       d_inc_A,
  output logic       d_inc_B,
  output logic       d_clr,
  output logic       ball_reset,
  output logic       graph_still,
  output logic       game_over,
  output logic       winner,
  output logic [1:0] state_dbg
);

  localparam logic [ScoreW-1:0] WinVal   = ScoreW'(WIN_SCORE);
  localparam logic [TimerW-1:0] PauseVal = TimerW'(PAUSE_TICKS);

  state_e            state_q;
  logic              btn_start_q;
  logic [ScoreW-1:0] sc_a_q, sc_b_q;
  logic [ScoreW-1:0] sc_a_inc, sc_b_inc;
  logic              start_rise, can_start;
  logic              point_a, point_b, win_a, win_b;
  logic              timer_load, timer_tick, timer_done;

  assign start_rise = btn_start & ~btn_start_q;
  assign can_start  = (state_q == StIdle) || (state_q == StOver);

  // A simultaneous double miss scores nothing.
  assign point_a  = (state_q == StPlay) && miss_B && !miss_A;
  assign point_b  = (state_q == StPlay) && miss_A && !miss_B;
  assign sc_a_inc = sc_a_q + ScoreW'(1);
  assign sc_b_inc = sc_b_q + ScoreW'(1);
  assign win_a    = point_a && (sc_a_inc == WinVal);
  assign win_b    = point_b && (sc_b_inc == WinVal);

  // Load beats tick, so a tick coincident with entering SERVE is not counted.
  assign timer_load = (can_start && start_rise) || ((point_a || point_b) && !win_a && !win_b);
  assign timer_tick = refr_tick && (state_q == StServe);

  pong_pause_timer u_pause_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (PauseVal),
    .tick     (timer_tick),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      btn_start_q <= 1'b0;
      sc_a_q      <= '0;
      sc_b_q      <= '0;
      d_inc_A     <= 1'b0;
      d_inc_B     <= 1'b0;
      d_clr       <= 1'b0;
      ball_reset  <= 1'b0;
      graph_still <= 1'b1;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      btn_start_q <= btn_start;
      d_inc_A     <= 1'b0;
      d_inc_B     <= 1'b0;
      d_clr       <= 1'b0;
      ball_reset  <= 1'b0;
      unique case (state_q)
        StIdle, StOver: begin
          if (start_rise) begin
            state_q     <= StServe;
            d_clr       <= 1'b1;
            ball_reset  <= 1'b1;
            sc_a_q      <= '0;
            sc_b_q      <= '0;
            game_over   <= 1'b0;
            graph_still <= 1'b1;
          end
        end
        StServe: begin
          if (timer_done) begin
            state_q     <= StPlay;
            graph_still <= 1'b0;
          end
        end
        StPlay: begin
          if (point_a || point_b) begin
            ball_reset  <= 1'b1;
            graph_still <= 1'b1;
            d_inc_A     <= point_a;
            d_inc_B     <= point_b;
            if (point_a) sc_a_q <= sc_a_inc;
            if (point_b) sc_b_q <= sc_b_inc;
            if (win_a || win_b) begin
              state_q   <= StOver;
              game_over <= 1'b1;
              winner    <= win_b;
            end else begin
              state_q <= StServe;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
module tb_pong_match_ctrl;

  localparam int unsigned WinScore   = 3;
  localparam int unsigned PauseTicks = 120;

  logic       clk = 1'b0;
  logic       reset, refr_tick, btn_start, miss_A, miss_B;
  logic       d_inc_A, d_inc_B, d_clr, ball_reset, graph_still, game_over, winner;
  logic [1:0] state_dbg;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: match described by a few flags and counters.
  bit m_started, m_finished, m_pause, m_btn_prev;
  int m_left, m_won;
  int m_score[2];
  bit e_inc[2];
  bit e_clr, e_ball;

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .WIN_SCORE   (WinScore),
    .PAUSE_TICKS (PauseTicks)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .refr_tick   (refr_tick),
    .btn_start   (btn_start),
    .miss_A      (miss_A),
    .miss_B      (miss_B),
    .d_inc_A     (d_inc_A),
    .d_inc_B     (d_inc_B),
    .d_clr       (d_clr),
    .ball_reset  (ball_reset),
    .graph_still (graph_still),
    .game_over   (game_over),
    .winner      (winner),
    .state_dbg   (state_dbg)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_playing();
    return m_started && !m_finished && !m_pause;
  endfunction

  task automatic model_step(input bit rst, input bit btn, input bit ma, input bit mb,
                            input bit tk);
    bit rise;
    e_inc[0] = 0; e_inc[1] = 0; e_clr = 0; e_ball = 0;
    if (rst) begin
      m_started = 0; m_finished = 0; m_pause = 0; m_btn_prev = 0;
      m_left = 0; m_won = 0; m_score[0] = 0; m_score[1] = 0;
      return;
    end
    rise = btn && !m_btn_prev;
    m_btn_prev = btn;
    if (!m_started || m_finished) begin
      if (rise) begin
        m_started = 1; m_finished = 0; m_pause = 1; m_left = PauseTicks;
        m_score[0] = 0; m_score[1] = 0;
        e_clr = 1; e_ball = 1;
      end
    end else if (m_pause) begin
      if (tk && m_left > 0) m_left--;
      if (m_left == 0) m_pause = 0;
    end else if (ma != mb) begin
      int who;
      who = ma ? 1 : 0;  // miss_A is a point for B (index 1)
      m_score[who]++;
      e_inc[who] = 1;
      e_ball = 1;
      if (m_score[who] == WinScore) begin
        m_finished = 1;
        m_won = who;
      end else begin
        m_pause = 1;
        m_left = PauseTicks;
      end
    end
  endtask

  task automatic compare_all();
    int exp_state;
    if (!m_started) exp_state = 0;
    else if (m_finished) exp_state = 3;
    else if (m_pause) exp_state = 1;
    else exp_state = 2;
    check_eq("d_inc_A", 8'(d_inc_A), 8'(e_inc[0]));
    check_eq("d_inc_B", 8'(d_inc_B), 8'(e_inc[1]));
    check_eq("d_clr", 8'(d_clr), 8'(e_clr));
    check_eq("ball_reset", 8'(ball_reset), 8'(e_ball));
    check_eq("graph_still", 8'(graph_still), 8'(!m_playing()));
    check_eq("game_over", 8'(game_over), 8'(m_finished));
    check_eq("state_dbg", 8'(state_dbg), 8'(exp_state));
    if (m_finished) check_eq("winner", 8'(winner), 8'(m_won));
  endtask

  task automatic apply(input bit rst, input bit btn, input bit ma, input bit mb, input bit tk);
    reset = rst; btn_start = btn; miss_A = ma; miss_B = mb; refr_tick = tk;
    @(posedge clk);
    model_step(rst, btn, ma, mb, tk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    bit btn_lvl;
    bit found;
    btn_lvl = 0;

    repeat (3) apply(1, 0, 0, 0, 0);
    check_eq("reset_winner", 8'(winner), 8'd0);

    // Held start button: a single clear and ball reset.
    repeat (5) apply(0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 0);

    // Wait for play, then a double miss must score nothing.
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (m_playing()) found = 1;
      else apply(0, 0, 0, 0, 1'($urandom_range(0, 1)));
    end
    check_eq("reached_play", 8'(found), 8'd1);
    if (found) begin
      apply(0, 0, 1, 1, 0);
      apply(0, 0, 0, 0, 0);
    end

    // Mid-match reset must not issue a clear; a later start does.
    apply(1, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0);

    for (int i = 0; i < 40000; i++) begin
      bit rst, ma, mb, tk;
      if ($urandom_range(0, 39) == 0) btn_lvl = !btn_lvl;
      rst = ($urandom_range(0, 4999) == 0);
      ma  = ($urandom_range(0, 11) == 0);
      mb  = ($urandom_range(0, 11) == 0);
      tk  = ($urandom_range(0, 3) != 0);
      apply(rst, btn_lvl, ma, mb, tk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
